// File: rtl/toy_lsu_issue_arb_if.sv
// Purpose: AGU-side request bundle plus registered issue bundle toward the LSU fanout.
// Latency: none (wires only).
// Backpressure: s_rdy per AGU toward the requesters, m_rdy from the fanout.
interface toy_lsu_issue_arb_if #(
    parameter int NUM_REQ = 2
);
    localparam int IDX_W = $clog2(NUM_REQ);

    // mem_req_opcode is carried untouched; the fanout decides load vs store.
    typedef struct packed {
        logic        mem_req_opcode;
        logic [3:0]  tag;
        logic [31:0] addr;
    } agu_pkg_t;

    logic [NUM_REQ-1:0]   s_vld;
    logic [NUM_REQ-1:0]   s_rdy;
    agu_pkg_t [NUM_REQ-1:0] s_pld;
    logic                 flush;
    logic                 m_vld;
    logic                 m_rdy;
    agu_pkg_t             m_pld;
    logic [IDX_W-1:0]     m_src;

    modport master (
        output s_vld, s_pld, flush, m_rdy,
        input  s_rdy, m_vld, m_pld, m_src
    );

    modport slave (
        input  s_vld, s_pld, flush, m_rdy,
        output s_rdy, m_vld, m_pld, m_src
    );
endinterface

// File: rtl/toy_lsu_issue_arb.sv
// Purpose: shares the single LSU fanout issue slot between NUM_REQ AGU pipes (round-robin + starvation override).
// Latency: an accept at edge N presents m_vld/m_pld/m_src in cycle N+1; one issue per cycle while m_rdy stays high.
// Backpressure: s_rdy only when the output entry is empty or draining and no flush; m_* are register outputs only.
module toy_lsu_issue_arb #(
    parameter int NUM_REQ    = 2,
    parameter int STARVE_LIM = 8,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    toy_lsu_issue_arb_if.slave bus,
    output logic [CNT_W-1:0]   stall_cnt
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [IDX_W-1:0]     rr_ptr;
    logic [3:0]           wait_cnt [NUM_REQ];
    logic [2*NUM_REQ-1:0] vld_dbl;
    logic [NUM_REQ-1:0]   rot_vld;
    logic [IDX_W:0]       rr_sum;
    logic [IDX_W-1:0]     win;
    logic                 found;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   rdy;
    logic                 load_en;
    logic                 accept;

    // Winner selection: a starved requester (lowest index) beats round-robin order from rr_ptr.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        rr_sum  = '0;
        // Rotating a doubled copy puts requester rr_ptr at bit 0, so the search needs no wrap logic.
        vld_dbl = {bus.s_vld, bus.s_vld} >> rr_ptr;
        rot_vld = vld_dbl[NUM_REQ-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.s_vld[i] && (wait_cnt[i] == LIM)) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot_vld[k]) begin
                found  = 1'b1;
                rr_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
                    rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
                end
                win = rr_sum[IDX_W-1:0];
            end
        end
    end

    // Accept gating: the slot can load when empty or draining this cycle, never during a flush.
    always_comb begin
        load_en = (~bus.m_vld | bus.m_rdy) & ~bus.flush;
        gnt     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = found && (win == IDX_W'(i));
        end
        rdy    = rst ? '0 : (gnt & {NUM_REQ{load_en}});
        accept = |(bus.s_vld & rdy);
    end

    assign bus.s_rdy = rdy;

    // Output entry and round-robin pointer: load on accept, drop on flush or plain drain, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_vld <= 1'b0;
            bus.m_pld <= '0;
            bus.m_src <= '0;
            rr_ptr    <= '0;
        end else if (bus.flush) begin
            bus.m_vld <= 1'b0;
        end else if (accept) begin
            bus.m_vld <= 1'b1;
            bus.m_src <= win;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (win == IDX_W'(i)) begin
                    bus.m_pld <= bus.s_pld[i];
                end
            end
            // Pointer moves past the winner even when it won by starvation override.
            if (win == IDX_W'(NUM_REQ-1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= win + 1'b1;
            end
        end else if (bus.m_vld && bus.m_rdy) begin
            bus.m_vld <= 1'b0;
        end
    end

    // Per-requester lost-arbitration counters; frozen while the slot is blocked.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                wait_cnt[i] <= '0;
            end else if (!bus.s_vld[i] || (gnt[i] && load_en) || bus.flush) begin
                wait_cnt[i] <= '0;
            end else if (load_en && !gnt[i] && (wait_cnt[i] != LIM)) begin
                wait_cnt[i] <= wait_cnt[i] + 4'd1;
            end
        end
    end

    // Downstream stall counter: saturates at all-ones, counts flush cycles too.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bus.m_vld && !bus.m_rdy && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/toy_lsu_issue_arb.md
# toy_lsu_issue_arb

Issue arbiter and output register stage in front of the LSU load/store fanout. It shares the single fanout issue slot between `NUM_REQ` AGU pipes. Arbitration is round-robin with a starvation override. The output is registered so the fanout's combinational hazard-driven ready never reaches the AGUs. It also flushes in-flight issue and counts downstream stall cycles for performance monitoring.

## Interface
- `NUM_REQ`, default 2: number of AGU requesters; legal range 2..4.
- `STARVE_LIM`, default 8: consecutive lost arbitration cycles before forced grant; legal range 1..15.
- `CNT_W`, default 16: width of the stall performance counter.
- `IDX_W`: local, `$clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_vld`  in  NUM_REQ  per-AGU request valid.
- `s_rdy`  out  NUM_REQ  per-AGU accept; at most one bit set per cycle.
- `s_pld`  in  NUM_REQ x agu_pkg  per-AGU payload.
- `flush`  in  1  pipeline flush; drops the registered entry.
- `m_vld`  out  1  registered issue valid to fanout `s_vld`.
- `m_rdy`  in  1  fanout `s_rdy` (low while hazard_flag is set).
- `m_pld`  out  agu_pkg  registered payload to fanout `s_pld`.
- `m_src`  out  IDX_W  index of the AGU that supplied the current `m_pld`.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `m_vld & ~m_rdy`.

## Operation
- Output register holds one entry: `m_vld`, `m_pld` and `m_src`.
- `load_en = (~m_vld | m_rdy) & ~flush`.
- `s_rdy[i] = load_en & gnt[i]`. `gnt` is one-hot or zero and is computed combinationally from `s_vld`, `rr_ptr` and `wait_cnt`.
- Grant priority:
  1. Forced grant. If any requester has `wait_cnt[i] == STARVE_LIM` and `s_vld[i]` set, the lowest such index wins.
  2. Round-robin. Otherwise the first `i` with `s_vld[i]` set wins, searching upward from `rr_ptr` and wrapping modulo NUM_REQ.
- On an accept (`|(s_vld & s_rdy)`):
  - `m_pld <= s_pld[win]`, `m_src <= win`, `m_vld <= 1`.
  - `rr_ptr <= (win + 1) mod NUM_REQ`. This update also applies after a forced grant.
- No accept and `m_vld & m_rdy`: `m_vld <= 0`.
- Otherwise `m_vld`, `m_pld` and `m_src` hold.
- `wait_cnt[i]`, 4 bits, per cycle, in this order:
  - cleared if `~s_vld[i]`, if `gnt[i] & load_en`, or if `flush`;
  - else incremented, saturating at STARVE_LIM, if `s_vld[i] & load_en & ~gnt[i]`;
  - else held. The counter does not advance while the slot is blocked.
- `flush`: `m_vld <= 0` next cycle whatever `m_rdy` is, and all `s_rdy` are 0 that cycle. `rr_ptr` and `stall_cnt` are not affected.
- `stall_cnt` increments on every cycle with `m_vld & ~m_rdy`, including a flush cycle, and saturates at all-ones. It never wraps.
- Load/store type (`mem_req_opcode`) is passed through untouched. Steering to load or store is the fanout's job.

## Timing
- Reset values: `m_vld=0`, `m_pld='0`, `m_src=0`, `stall_cnt=0`, `rr_ptr=0`, all `wait_cnt=0`. `s_rdy=0` during the reset cycle.
- Latency: accept at edge N gives `m_vld=1` with the payload visible in cycle N+1.
- Throughput: 1 issue per cycle while `m_rdy` is held high, because the entry drains and refills in the same cycle.
- While `m_vld & ~m_rdy`, `m_pld` and `m_src` are stable and `s_rdy` is all zero.
- Paths: `s_rdy` depends combinationally on `m_rdy`. `m_vld`, `m_pld` and `m_src` are register outputs only.
- Reset asserted mid-stall discards the entry and clears `stall_cnt` on the next edge.
- Flush and an accepting handshake in the same cycle: the downstream handshake completes, no new entry is loaded, and `m_vld=0` next cycle.

## Test plan
- **Reset then single request:** `rst` for 2 cycles, then `s_vld=2'b01` with pld A for 1 cycle. Required: `s_rdy=01` that cycle, `m_vld=1`, `m_pld=A`, `m_src=0` next cycle, then `m_vld=0` with `m_rdy=1`.
- **Round-robin:** both AGUs request continuously with `m_rdy=1` for 6 cycles. Required: `m_src` sequence 0,1,0,1,0,1, one issue per cycle, `stall_cnt=0`.
- **Hazard stall:** entry B held with `m_rdy=0` for 5 cycles. Required: `m_pld=B` stable, `s_rdy=0`, `stall_cnt=5`. When `m_rdy` returns to 1, the next granted request appears the following cycle.
- **Starvation override:** `STARVE_LIM=2`, NUM_REQ=3. AGU0 requests every cycle; AGU2 requests throughout but is kept losing by forcing `rr_ptr` via the AGU1 pattern. Required: AGU2 is granted no later than its third eligible cycle, and its `wait_cnt` returns to 0.
- **Flush:** `flush` together with `m_vld=1`, `m_rdy=0` and both `s_vld` set. Required: `s_rdy=0` that cycle, `m_vld=0` next cycle, `wait_cnt` cleared, `rr_ptr` unchanged.
- **Counter saturation:** `CNT_W=4`, `m_rdy=0` for 20 cycles with an entry held. Required: `stall_cnt=15` and held at 15.
